// File: rtl/display_scan_4d.sv
// Scan controller for a 4-digit multiplexed 7-segment display: drives the digit
// mux select and the active-low anodes, with a blanking interval at the start of each slot.
module display_scan_4d #(
  parameter int PRESCALE = 12000,
  parameter int BLANK    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit_en,
  output logic [1:0] sel,
  output logic [3:0] an,
  output logic       tick,
  output logic       frame
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST      = W'(PRESCALE - 1);
  localparam logic [W-1:0] BLANK_CNT = W'(BLANK);

  logic [W-1:0] pcnt;
  logic [W-1:0] pcnt_next;
  logic [1:0]   sel_next;
  logic [3:0]   an_next;
  logic         wrap;

  // Outputs are registered from the next-state values so an/tick/frame move on the same edge as sel.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, otherwise a latch is inferred.
    wrap      = en && (pcnt == LAST);
    pcnt_next = pcnt;
    sel_next  = sel;
    an_next   = 4'b1111;
    if (wrap) begin
      pcnt_next = '0;
      sel_next  = sel + 2'd1;
    end else if (en) begin
      pcnt_next = pcnt + 1'b1;
    end
    if (en && (pcnt_next >= BLANK_CNT) && digit_en[sel_next]) begin
      an_next = ~(4'b0001 << sel_next);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt  <= '0;
      sel   <= 2'd0;
      an    <= 4'b1111;
      tick  <= 1'b0;
      frame <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      pcnt  <= pcnt_next;
      sel   <= sel_next;
      an    <= an_next;
      tick  <= wrap;
      frame <= wrap && (sel_next == 2'd0);
    end
  end

endmodule

// File: tb/tb_display_scan_4d.sv
// Self-checking bench for display_scan_4d: directed scenarios plus random en/digit_en,
// compared against a model that tracks elapsed enabled cycles since reset.
module tb_display_scan_4d;

  localparam int P = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] digit_en = 4'hf;
  logic [1:0] sel;
  logic [3:0] an;
  logic       tick;
  logic       frame;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Model: t counts enabled edges since reset; slot = t / P, position in slot = t % P.
  int         t;
  logic [3:0] m_an;
  logic       m_tick;
  logic       m_frame;

  display_scan_4d #(.PRESCALE(P), .BLANK(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .digit_en (digit_en),
    .sel      (sel),
    .an       (an),
    .tick     (tick),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] m_sel();
    return 2'((t / P) % 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    m_an    = 4'hf;
    m_tick  = 1'b0;
    m_frame = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic [3:0] de);
    if (e) begin
      t++;
      m_tick  = (t % P) == 0;
      m_frame = (t % (4 * P)) == 0;
      m_an    = ((t % P) >= B && de[m_sel()]) ? ~(4'b0001 << m_sel()) : 4'hf;
    end else begin
      m_tick  = 1'b0;
      m_frame = 1'b0;
      m_an    = 4'hf;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_sel"},    32'(sel),   32'(m_sel()));
    chk({ph, "_an"},     32'(an),    32'(m_an));
    chk({ph, "_tick"},   32'(tick),  32'(m_tick));
    chk({ph, "_frame"},  32'(frame), 32'(m_frame));
    chk({ph, "_onehot"}, 32'($countones(~an) <= 1), 32'd1);
  endtask

  // Called at a falling edge: drive inputs, take the rising edge, check 1 time unit later.
  task automatic cycle(input string ph, input logic e, input logic [3:0] de);
    en       = e;
    digit_en = de;
    @(posedge clk);
    model_edge(e, de);
    #1;
    check_all(ph);
    @(negedge clk);
  endtask

  initial begin
    int n;

    // Reset takes effect before the first clock edge.
    en       = 1'b1;
    digit_en = 4'hf;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    check_all("reset_hold");
    rst = 1'b0;

    // Slot timing and a full frame with all digits enabled.
    repeat (40) cycle("frame", 1'b1, 4'hf);

    // Digit 2 masked for a whole frame.
    repeat (32) cycle("mask", 1'b1, 4'b1011);

    // Freeze at sel=1, slot cycle 5.
    n = 0;
    while ((t % (4 * P)) != (P + 5) && n < 64) begin
      cycle("to_freeze", 1'b1, 4'hf);
      n++;
    end
    chk("freeze_pos_sel", 32'(sel), 32'd1);
    repeat (10) cycle("freeze", 1'b0, 4'hf);
    n = 0;
    do begin
      cycle("resume", 1'b1, 4'hf);
      n++;
    end while (sel != 2'd2 && n < 10);
    chk("resume_cycles", 32'(n), 32'd3);

    // Asynchronous reset while sel=3, pcnt=6.
    n = 0;
    while ((t % (4 * P)) != (3 * P + 6) && n < 64) begin
      cycle("to_midrst", 1'b1, 4'hf);
      n++;
    end
    chk("midrst_pos_sel", 32'(sel), 32'd3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) cycle("post_rst", 1'b1, 4'hf);

    // Random enable gaps and digit masks.
    repeat (300) cycle("rand", $urandom_range(0, 3) != 0, 4'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/display_scan_4d.md
# display_scan_4d

Time-multiplexing scan controller for a 4-digit 7-segment display, sitting directly upstream of the 4-bit 4:1 digit mux. It generates the 2-bit `sel` that picks which nibble (d0..d3) the mux presents on `f`. It also generates the matching active-low anode enables so the BCD/7-segment decoder downstream of the mux drives exactly one digit at a time. A blanking interval at the start of each digit slot suppresses ghosting while `sel` and the segment data settle.

## Interface
Parameters:
- `PRESCALE`, default 12000: clock cycles per digit slot; at 12 MHz this gives a 1 ms slot and a 250 Hz frame. Must be ≥ 2.
- `BLANK`, default 16: cycles at the start of each slot with all anodes off. Must satisfy 0 ≤ BLANK < PRESCALE.

Ports:
- `clk`  in  1: single system clock; everything is on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `en`  in  1: scan enable. When low, the scan freezes and the display is dark.
- `digit_en`  in  4: per-digit enable mask, bit i corresponding to digit i.
- `sel`  out  2: digit index, connected directly to the mux select.
- `an`  out  4: anode enables, active-low; bit i corresponds to digit i.
- `tick`  out  1: one-cycle pulse in the first cycle of each new slot.
- `frame`  out  1: one-cycle pulse in the first cycle of the slot where `sel` returns to 0.

## Operation
- Internal slot counter `pcnt`, width $clog2(PRESCALE), counts 0..PRESCALE-1 while `en`=1.
- When `pcnt`=PRESCALE-1 and `en`=1, on the next edge:
  - `pcnt` goes to 0.
  - `sel` increments modulo 4 (3 wraps to 0).
  - `tick` goes to 1 for that one cycle.
  - `frame` goes to 1 for that cycle only if the new `sel` is 0.
- Anode rule:
  - `an` = ~(4'b0001 << sel) when `en`=1, `pcnt` ≥ BLANK, and `digit_en[sel]`=1.
  - Otherwise `an` = 4'b1111.
  - Exactly zero or one anode bit is low at any time.
- A disabled digit (`digit_en[i]`=0) still occupies its full slot, so `sel` timing is independent of `digit_en`. Its anode stays high for the entire slot.
- `en`=0:
  - `pcnt` and `sel` hold their values.
  - `an` = 4'b1111, `tick` = 0, `frame` = 0.
  - When `en` returns to 1, counting resumes from the held `pcnt`.
- All outputs come from registers. `an`, `tick` and `frame` are computed from the next-state `pcnt`/`sel`/`en`, so they change on the same edge as `sel`. There are no combinational paths from inputs to outputs.
- `digit_en` is sampled every cycle. A change takes effect on the anode one edge later, including mid-slot.

## Timing
- Reset values (asynchronous, immediate): `pcnt`=0, `sel`=0, `an`=4'b1111, `tick`=0, `frame`=0.
- After reset is released with `en`=1:
  - The first slot is `sel`=0. It is a full slot but produces no `tick` and no `frame`.
  - The first `tick` occurs on the PRESCALE-th edge.
- Within a slot, counting the slot-start edge as cycle 0:
  - Cycles 0..BLANK-1: `an`=1111.
  - Cycles BLANK..PRESCALE-1: the selected anode is low.
- With BLANK=0, the anode turns on in the same cycle that `sel` changes.
- Frame period is 4·PRESCALE cycles. `frame` coincides with exactly one `tick` per frame.
- Reset asserted mid-slot: all outputs return to their reset values immediately, without waiting for a clock edge. No partial `tick` is generated.
- `en` dropping in the same cycle that `pcnt`=PRESCALE-1: the wrap does not occur. `pcnt` holds at PRESCALE-1, and the wrap happens on the first enabled edge afterwards.
- Mux + decoder settle time must be less than BLANK clock periods. This is the integration requirement that BLANK exists to satisfy.

## Test plan
All scenarios use PRESCALE=8 and BLANK=2.

1. **Reset.** Assert `rst` with `en`=1 → `sel`=0, `an`=1111, `tick`=0, `frame`=0, all immediately and before any clock edge.
2. **Slot timing.** Release `rst`, set `en`=1, `digit_en`=1111 →
   - `an`=1111 for 2 cycles, then 1110 for 6 cycles.
   - On edge 8: `sel`=1, `tick`=1, `an`=1111; then `an`=1101 from edge 10.
3. **Full frame.** Run 40 cycles →
   - `sel` sequence is 0,1,2,3,0.
   - `tick` every 8 cycles.
   - `frame`=1 only on edge 32.
   - `an` never has more than one low bit.
4. **Digit masking.** Set `digit_en`=1011 → during the `sel`=2 slot `an` stays 1111 for all 8 cycles. Slots 0, 1 and 3 are unaffected and `sel` timing is unchanged.
5. **Scan freeze.** Drop `en` at slot cycle 5 while `sel`=1 and hold it low for 10 cycles →
   - `an`=1111, `sel` stays 1, no `tick`.
   - After `en` returns, 3 more cycles elapse before `sel`=2.
6. **Reset mid-slot.** Pulse `rst` asynchronously while `sel`=3 and `pcnt`=6 → `sel`=0 and `an`=1111 immediately. After release, the bench observes a full 8-cycle slot 0 with no `tick`.
